// File: rtl/mul_pkg.sv
// mul_pkg: shared width, iteration count and sequencer state type for mul_seq.
package mul_pkg;
  localparam int WIDTH = 32;
  localparam int ITERS = 32;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/Add.sv
// Add: 32-bit carry-lookahead adder built from eight 4-bit lookahead groups.
module Add (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);
  logic [31:0] g, p, c;
  logic [8:0] gc;
  assign g = a & b;
  assign p = a ^ b;
  assign gc[0] = cin;
  for (genvar k = 0; k < 8; k++) begin : grp
    logic [3:0] gg, pp;
    assign gg = g[4*k +: 4];
    assign pp = p[4*k +: 4];
    assign c[4*k]   = gc[k];
    assign c[4*k+1] = gg[0] | (pp[0] & gc[k]);
    assign c[4*k+2] = gg[1] | (pp[1] & gg[0]) | (pp[1] & pp[0] & gc[k]);
    assign c[4*k+3] = gg[2] | (pp[2] & gg[1]) | (pp[2] & pp[1] & gg[0]) | (pp[2] & pp[1] & pp[0] & gc[k]);
    assign gc[k+1]  = gg[3] | (pp[3] & gg[2]) | (pp[3] & pp[2] & gg[1]) | (pp[3] & pp[2] & pp[1] & gg[0])
                    | (&pp & gc[k]);
  end
  assign sum = p ^ c;
  assign cout = gc[8];
endmodule

// File: rtl/mul_seq.sv
// mul_seq: unsigned 32x32 shift-add multiplier sharing one CLA adder over 32 cycles.
// Define MUL_OVF_EN to add the ovf output (nonzero upper half flagged during done).
module mul_seq
  import mul_pkg::*;
(
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic [WIDTH-1:0] RA,
  input  logic [WIDTH-1:0] RB,
  output logic             busy,
  output logic             done,
`ifdef MUL_OVF_EN
  output logic             ovf,
`endif
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);
  state_t state, state_nxt;
  logic [WIDTH-1:0] a, q, m, sum;
  logic [4:0] count;
  logic carry;
  Add u_add (.a(a), .b(q[0] ? m : '0), .cin(1'b0), .sum(sum), .cout(carry));
  always_ff @(posedge clock or posedge clear)
    if (clear) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state == IDLE ? (start ? RUN : IDLE)
              : state == RUN  ? (count == 5'(ITERS - 1) ? DONE : RUN)
              : IDLE;
  end
  always_comb begin
    busy = state != IDLE;
    done = state == DONE;
`ifdef MUL_OVF_EN
    ovf = done & |a;
`endif
  end
  // The adder carry-out shifts into the top of A so no product bit is lost.
  always_ff @(posedge clock or posedge clear)
    if (clear) begin
      a <= '0;
      q <= '0;
      m <= '0;
      count <= '0;
    end else if (state == IDLE && start) begin
      a <= '0;
      q <= RB;
      m <= RA;
      count <= '0;
    end else if (state == RUN) begin
      a <= {carry, sum[WIDTH-1:1]};
      q <= {sum[0], q[WIDTH-1:1]};
      count <= count + 5'd1;
    end
  assign HI = a;
  assign LO = q;
endmodule

// File: tb/tb_mul_seq.sv
// tb_mul_seq: scoreboard bench for mul_seq; expected products queued at start, checked on done.
module tb_mul_seq;
  logic clock = 0, clear = 1, start = 0;
  logic [31:0] RA = 0, RB = 0;
  logic busy, done;
  logic [31:0] HI, LO;
`ifdef MUL_OVF_EN
  logic ovf;
`endif
  int checks = 0, failures = 0, dones = 0, n, d0;
  logic [63:0] sb[$];

  mul_seq dut (
    .clock(clock), .clear(clear), .start(start), .RA(RA), .RB(RB),
    .busy(busy), .done(done),
`ifdef MUL_OVF_EN
    .ovf(ovf),
`endif
    .HI(HI), .LO(LO)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(negedge clock) if (done) begin
    logic [63:0] e;
    dones++;
    if (sb.size() == 0) check("unexpected_done", 64'd1, 64'd0);
    else begin
      e = sb.pop_front();
      check("hi", 64'(HI), 64'(e[63:32]));
      check("lo", 64'(LO), 64'(e[31:0]));
`ifdef MUL_OVF_EN
      check("ovf", 64'(ovf), 64'(|e[63:32]));
`endif
    end
  end

  task automatic drive(input logic [31:0] a, input logic [31:0] b);
    RA = a;
    RB = b;
    start = 1;
    sb.push_back(64'(a) * 64'(b));
    @(posedge clock);
    #1 start = 0;
  endtask

  task automatic wait_done(output int k);
    k = 1;
    do begin
      @(posedge clock);
      k++;
      #1;
    end while (!done && k < 40);
  endtask

  task automatic mul(input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    drive(a, b);
    wait_done(n);
    check("latency", 64'(n), 64'd33);
    @(posedge clock);
    #1 check("busy_after", 64'(busy), 64'd0);
  endtask

  initial begin
    #1;
    check("rst_hi", 64'(HI), 64'd0);
    check("rst_lo", 64'(LO), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
`ifdef MUL_OVF_EN
    check("rst_ovf", 64'(ovf), 64'd0);
`endif
    @(negedge clock);
    clear = 0;
    mul(32'd3, 32'd5);
    mul(32'hFFFFFFFF, 32'hFFFFFFFF);
    mul(32'h00010000, 32'h00010000);
    mul(32'd0, 32'hFFFFFFFF);
    mul(32'h80000000, 32'd2);
    // start pulses during RUN and in the DONE cycle must be ignored
    d0 = dones;
    @(negedge clock);
    drive(32'd7, 32'd6);
    repeat (9) @(posedge clock);
    #1 check("busy_run", 64'(busy), 64'd1);
    start = 1;
    RA = 1;
    RB = 1;
    @(posedge clock);
    #1 start = 0;
    wait_done(n);
    start = 1;
    @(posedge clock);
    #1 start = 0;
    check("busy_ignored", 64'(busy), 64'd0);
    repeat (3) @(posedge clock);
    #1 check("one_done", 64'(dones - d0), 64'd1);
    check("idle_hold", 64'(busy), 64'd0);
    check("hold_lo", 64'(LO), 64'd42);
    // clear mid-run aborts immediately, then start is accepted on the first edge
    d0 = dones;
    @(negedge clock);
    drive(32'h12345678, 32'h9ABCDEF0);
    repeat (9) @(posedge clock);
    #1 clear = 1;
    #1;
    check("clr_hi", 64'(HI), 64'd0);
    check("clr_lo", 64'(LO), 64'd0);
    check("clr_busy", 64'(busy), 64'd0);
    check("clr_done", 64'(done), 64'd0);
    sb.delete();
    @(negedge clock);
    clear = 0;
    drive(32'd2, 32'd2);
    check("accept_after_clr", 64'(busy), 64'd1);
    wait_done(n);
    check("latency_clr", 64'(n), 64'd33);
    @(posedge clock);
    #1 check("clr_dones", 64'(dones - d0), 64'd1);
    for (int i = 0; i < 6; i++) mul($urandom, $urandom);
    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
